// File: rtl/text_console_pkg.sv
// text_console_pkg: shared types and constants for the text console.
//   t_console_state  - controller states (full clear, row clear, accepting text)
//   CHAR_*           - control codes interpreted by the character stream
//   CHAR_PRINT_*     - inclusive bounds of the printable ASCII range
package text_console_pkg;

  typedef enum logic [1:0] {
    StClearAll,
    StClearRow,
    StReady
  } t_console_state;

  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_BS = 8'h08;
  localparam logic [7:0] CHAR_FF = 8'h0C;

  localparam logic [7:0] CHAR_PRINT_MIN = 8'h20;
  localparam logic [7:0] CHAR_PRINT_MAX = 8'h7E;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= CHAR_PRINT_MIN) && (c <= CHAR_PRINT_MAX);
  endfunction

endpackage

// File: rtl/text_console_ram.sv
// text_console_ram: simple dual-port character RAM, 2**ADDR_BITS x 8.
//   in_clk       clock
//   in_rst       asynchronous active-low reset (read register only)
//   in_we        write enable
//   in_wr_addr   write address
//   in_wr_data   write data
//   in_rd_addr   read address
//   out_rd_data  registered read data, read-first on address collision
module text_console_ram #(
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic                 in_we,
  input  logic [ADDR_BITS-1:0] in_wr_addr,
  input  logic [7:0]           in_wr_data,
  input  logic [ADDR_BITS-1:0] in_rd_addr,
  output logic [7:0]           out_rd_data
);

  logic [7:0] r_mem [2**ADDR_BITS];
  logic [7:0] r_rd_data;

  // Array contents are not reset; the controller clears them after reset.
  always_ff @(posedge in_clk) begin
    if (in_we) begin
      r_mem[in_wr_addr] <= in_wr_data;
    end
  end

  // Non-blocking read of the array gives the pre-write value on a collision.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      r_rd_data <= 8'h00;
    end else begin
      r_rd_data <= r_mem[in_rd_addr];
    end
  end

  assign out_rd_data = r_rd_data;

endmodule

// File: rtl/text_console.sv
// text_console: writable text buffer fed by a character stream.
//   in_clk, in_rst            clock, asynchronous active-low reset
//   in_char, in_char_valid    incoming ASCII character and its valid
//   out_char_ready            character accepted when valid && ready
//   in_clear                  pulse: restart a full-screen clear
//   out_busy                  full-screen clear in progress
//   in_rd_addr, out_rd_data   display read port, one cycle latency
//   out_cursor_x/y            registered cursor position
module text_console
  import text_console_pkg::*;
#(
  parameter int unsigned TEXT_COLS  = 20,
  parameter int unsigned TEXT_ROWS  = 6,
  parameter int unsigned ADDR_BITS  = 8,
  parameter logic [7:0]  CLEAR_CHAR = 8'h20
) (
  input  logic                         in_clk,
  input  logic                         in_rst,
  input  logic [7:0]                   in_char,
  input  logic                         in_char_valid,
  output logic                         out_char_ready,
  input  logic                         in_clear,
  output logic                         out_busy,
  input  logic [ADDR_BITS-1:0]         in_rd_addr,
  output logic [7:0]                   out_rd_data,
  output logic [$clog2(TEXT_COLS)-1:0] out_cursor_x,
  output logic [$clog2(TEXT_ROWS)-1:0] out_cursor_y
);

  localparam int unsigned XW    = $clog2(TEXT_COLS);
  localparam int unsigned YW    = $clog2(TEXT_ROWS);
  localparam int unsigned CELLS = TEXT_COLS * TEXT_ROWS;

  localparam logic [ADDR_BITS-1:0] LAST_CELL = ADDR_BITS'(CELLS - 1);
  localparam logic [ADDR_BITS-1:0] COLS_A    = ADDR_BITS'(TEXT_COLS);
  localparam logic [ADDR_BITS-1:0] ONE_A     = ADDR_BITS'(1);
  localparam logic [XW-1:0]        LAST_COL  = XW'(TEXT_COLS - 1);
  localparam logic [YW-1:0]        LAST_ROW  = YW'(TEXT_ROWS - 1);

  t_console_state       r_state, w_state_next;
  logic [ADDR_BITS-1:0] r_fill_addr, w_fill_next;
  logic [ADDR_BITS-1:0] r_row_base, w_row_base_next;
  logic [XW-1:0]        r_cursor_x, w_cursor_x_next;
  logic [YW-1:0]        r_cursor_y, w_cursor_y_next;
  logic                 r_rd_oor;

  logic                 w_accept;
  logic                 w_newline;
  logic                 w_we;
  logic [ADDR_BITS-1:0] w_wr_addr;
  logic [7:0]           w_wr_data;
  logic [7:0]           w_ram_rd;
  logic [ADDR_BITS-1:0] w_cur_addr;
  logic [ADDR_BITS-1:0] w_row_last;

  assign w_cur_addr = r_row_base + ADDR_BITS'(r_cursor_x);
  assign w_row_last = r_row_base + ADDR_BITS'(TEXT_COLS - 1);

  assign out_char_ready = (r_state == StReady) && !in_clear;
  assign out_busy       = (r_state == StClearAll);
  assign w_accept       = in_char_valid && out_char_ready;

  always_comb begin
    w_state_next    = r_state;
    w_fill_next     = r_fill_addr;
    w_row_base_next = r_row_base;
    w_cursor_x_next = r_cursor_x;
    w_cursor_y_next = r_cursor_y;
    w_newline       = 1'b0;
    w_we            = 1'b0;
    w_wr_addr       = r_fill_addr;
    w_wr_data       = CLEAR_CHAR;

    unique case (r_state)
      StClearAll: begin
        w_we            = 1'b1;
        w_fill_next     = r_fill_addr + ONE_A;
        w_row_base_next = '0;
        w_cursor_x_next = '0;
        w_cursor_y_next = '0;
        if (r_fill_addr == LAST_CELL) begin
          w_state_next = StReady;
        end
      end
      StClearRow: begin
        w_we        = 1'b1;
        w_fill_next = r_fill_addr + ONE_A;
        if (r_fill_addr == w_row_last) begin
          w_state_next = StReady;
        end
      end
      StReady: begin
        if (w_accept) begin
          if (is_printable(in_char)) begin
            w_we      = 1'b1;
            w_wr_addr = w_cur_addr;
            w_wr_data = in_char;
            if (r_cursor_x == LAST_COL) begin
              w_newline = 1'b1;
            end else begin
              w_cursor_x_next = r_cursor_x + XW'(1);
            end
          end else begin
            case (in_char)
              CHAR_LF: w_newline = 1'b1;
              CHAR_CR: w_cursor_x_next = '0;
              CHAR_BS: begin
                if (r_cursor_x != '0) begin
                  w_cursor_x_next = r_cursor_x - XW'(1);
                  w_we            = 1'b1;
                  w_wr_addr       = w_cur_addr - ONE_A;
                end
              end
              CHAR_FF: begin
                w_state_next = StClearAll;
                w_fill_next  = '0;
              end
              default: ;
            endcase
          end
        end
      end
      default: begin
        w_state_next = StClearAll;
        w_fill_next  = '0;
      end
    endcase

    // The row being entered is blanked; there is no scrolling.
    if (w_newline) begin
      w_cursor_x_next = '0;
      w_state_next    = StClearRow;
      if (r_cursor_y == LAST_ROW) begin
        w_cursor_y_next = '0;
        w_row_base_next = '0;
        w_fill_next     = '0;
      end else begin
        w_cursor_y_next = r_cursor_y + YW'(1);
        w_row_base_next = r_row_base + COLS_A;
        w_fill_next     = r_row_base + COLS_A;
      end
    end

    if (in_clear) begin
      w_state_next = StClearAll;
      w_fill_next  = '0;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      r_state     <= StClearAll;
      r_fill_addr <= '0;
      r_row_base  <= '0;
      r_cursor_x  <= '0;
      r_cursor_y  <= '0;
      r_rd_oor    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_fill_addr <= w_fill_next;
      r_row_base  <= w_row_base_next;
      r_cursor_x  <= w_cursor_x_next;
      r_cursor_y  <= w_cursor_y_next;
      r_rd_oor    <= (32'(in_rd_addr) >= CELLS);
    end
  end

  text_console_ram #(
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .in_clk      (in_clk),
    .in_rst      (in_rst),
    .in_we       (w_we),
    .in_wr_addr  (w_wr_addr),
    .in_wr_data  (w_wr_data),
    .in_rd_addr  (in_rd_addr),
    .out_rd_data (w_ram_rd)
  );

  // Addresses past the text area always read as blank.
  assign out_rd_data  = r_rd_oor ? CLEAR_CHAR : w_ram_rd;
  assign out_cursor_x = r_cursor_x;
  assign out_cursor_y = r_cursor_y;

endmodule

// File: tb/tb_text_console.sv
module tb_text_console;
  import text_console_pkg::*;

  localparam int K_RD   = 0;
  localparam int K_CX   = 1;
  localparam int K_CY   = 2;
  localparam int K_RDY  = 3;
  localparam int K_BUSY = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ch;
  logic       vld;
  logic       rdy;
  logic       clr;
  logic       busy;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic [4:0] cx;
  logic [2:0] cy;

  always #5 clk = ~clk;

  text_console #(
    .TEXT_COLS  (20),
    .TEXT_ROWS  (6),
    .ADDR_BITS  (8),
    .CLEAR_CHAR (8'h20)
  ) dut (
    .in_clk         (clk),
    .in_rst         (rst),
    .in_char        (ch),
    .in_char_valid  (vld),
    .out_char_ready (rdy),
    .in_clear       (clr),
    .out_busy       (busy),
    .in_rd_addr     (rd_addr),
    .out_rd_data    (rd_data),
    .out_cursor_x   (cx),
    .out_cursor_y   (cy)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int gaps   = 0;
  int meas;

  typedef struct {
    string      name;
    int         kind;
    logic [7:0] exp;
  } item_t;

  item_t sb_q[$];
  logic  req   = 1'b0;
  logic  req_d = 1'b0;

  // A request made in cycle n is answered by the DUT after the next edge.
  always @(posedge clk) req_d <= req;

  always @(negedge clk) begin
    item_t      it;
    logic [7:0] act;
    if (req_d) begin
      n_chk++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_underflow: output with no expected entry");
      end else begin
        it = sb_q.pop_front();
        case (it.kind)
          K_RD:    act = rd_data;
          K_CX:    act = {3'b0, cx};
          K_CY:    act = {5'b0, cy};
          K_RDY:   act = {7'b0, rdy};
          default: act = {7'b0, busy};
        endcase
        if (act !== it.exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input string name, input int kind, input logic [7:0] exp);
    item_t it;
    it.name = name;
    it.kind = kind;
    it.exp  = exp;
    sb_q.push_back(it);
  endtask

  task automatic probe(input string name, input int kind, input logic [7:0] exp);
    req = 1'b1;
    push(name, kind, exp);
    tick();
    req = 1'b0;
  endtask

  task automatic read_range(input string name, input int lo, input int hi,
                            input logic [7:0] exp);
    for (int a = lo; a <= hi; a++) begin
      rd_addr = 8'(a);
      req     = 1'b1;
      push(name, K_RD, exp);
      tick();
    end
    req = 1'b0;
  endtask

  task automatic send(input logic [7:0] c);
    int w = 0;
    ch  = c;
    vld = 1'b1;
    while (rdy !== 1'b1 && w < 500) begin
      tick();
      w++;
    end
    if (w >= 500) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: char %h not accepted within %0d cycles", c, w);
    end
    gaps += w;
    tick();
    vld = 1'b0;
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_notready(output int n);
    n = 0;
    while (rdy !== 1'b1 && n < 1000) begin
      n++;
      tick();
    end
  endtask

  initial begin
    rst     = 1'b0;
    ch      = 8'h00;
    vld     = 1'b0;
    clr     = 1'b0;
    rd_addr = 8'h00;
    repeat (3) tick();

    // Reset state.
    probe("rst_busy", K_BUSY, 8'h01);
    probe("rst_ready", K_RDY, 8'h00);
    probe("rst_cx", K_CX, 8'h00);
    probe("rst_cy", K_CY, 8'h00);
    probe("rst_rd_data", K_RD, 8'h00);

    // Power-up clear.
    rst = 1'b1;
    wait_busy(meas);
    check("init_busy_cycles", meas, 120);
    read_range("init_blank", 0, 119, 8'h20);
    read_range("oor_read", 200, 201, 8'h20);
    read_range("oor_read_top", 255, 255, 8'h20);
    probe("init_cx", K_CX, 8'h00);
    probe("init_cy", K_CY, 8'h00);
    probe("init_ready", K_RDY, 8'h01);

    // Back-to-back printable characters.
    gaps = 0;
    send(8'h41);
    send(8'h42);
    check("ab_ready_gaps", gaps, 0);
    probe("ab_cx", K_CX, 8'h02);
    probe("ab_cy", K_CY, 8'h00);
    read_range("ab_cell0", 0, 0, 8'h41);
    read_range("ab_cell1", 1, 1, 8'h42);

    // Form feed clears everything and homes the cursor.
    send(CHAR_FF);
    wait_busy(meas);
    check("ff_busy_cycles", meas, 120);
    read_range("ff_blank", 0, 1, 8'h20);

    // A full row wraps into a blanked next row.
    gaps = 0;
    for (int i = 0; i < 20; i++) send(8'h78);
    check("row_ready_gaps", gaps, 0);
    wait_notready(meas);
    check("row_clear_cycles", meas, 20);
    probe("wrap_cx", K_CX, 8'h00);
    probe("wrap_cy", K_CY, 8'h01);
    read_range("row0_x", 0, 19, 8'h78);
    read_range("row1_blank", 20, 20, 8'h20);

    // Down to the last row, then LF wraps to row 0 and blanks it.
    for (int i = 0; i < 4; i++) send(CHAR_LF);
    wait_notready(meas);
    probe("row5_cy", K_CY, 8'h05);
    send(CHAR_LF);
    wait_notready(meas);
    check("lf_wrap_clear_cycles", meas, 20);
    probe("lf_wrap_cx", K_CX, 8'h00);
    probe("lf_wrap_cy", K_CY, 8'h00);
    read_range("row0_reblank", 0, 19, 8'h20);

    // Backspace, carriage return and range boundaries on row 2.
    send(CHAR_LF);
    send(CHAR_LF);
    wait_notready(meas);
    send(CHAR_BS);
    probe("bs_at0_cx", K_CX, 8'h00);
    probe("bs_at0_cy", K_CY, 8'h02);
    gaps = 0;
    send(8'h61);
    send(8'h62);
    send(8'h63);
    send(CHAR_BS);
    check("abc_ready_gaps", gaps, 0);
    probe("bs_cx", K_CX, 8'h02);
    probe("bs_cy", K_CY, 8'h02);
    read_range("bs_cell40", 40, 40, 8'h61);
    read_range("bs_cell41", 41, 41, 8'h62);
    read_range("bs_cell42", 42, 42, 8'h20);
    send(CHAR_CR);
    probe("cr_cx", K_CX, 8'h00);
    probe("cr_cy", K_CY, 8'h02);
    read_range("cr_cell41", 41, 41, 8'h62);
    send(8'h7F);
    probe("del_ignored_cx", K_CX, 8'h00);
    read_range("del_cell40", 40, 40, 8'h61);
    send(8'h7E);
    probe("tilde_cx", K_CX, 8'h01);
    read_range("tilde_cell40", 40, 40, 8'h7E);

    // in_clear during a row clear restarts a full clear.
    send(CHAR_LF);
    repeat (5) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    wait_busy(meas);
    check("clear_in_row_busy_cycles", meas, 120);
    probe("clear_cx", K_CX, 8'h00);
    probe("clear_cy", K_CY, 8'h00);
    read_range("clear_cell40", 40, 40, 8'h20);

    // Valid together with in_clear is not accepted.
    ch  = 8'h5A;
    vld = 1'b1;
    clr = 1'b1;
    #1;
    check("clear_blocks_ready", int'(rdy), 0);
    tick();
    vld = 1'b0;
    clr = 1'b0;
    wait_busy(meas);
    check("clear_pulse_busy_cycles", meas, 120);
    probe("after_clear_cx", K_CX, 8'h00);

    // Reset in the middle of a full clear.
    send(8'h51);
    send(CHAR_FF);
    rd_addr = 8'd1;
    repeat (50) tick();
    rst = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 1);
    check("midrst_ready", int'(rdy), 0);
    check("midrst_rd_data", int'(rd_data), 0);
    check("midrst_cx", int'(cx), 0);
    check("midrst_cy", int'(cy), 0);
    tick();
    tick();
    rst = 1'b1;
    wait_busy(meas);
    check("midrst_busy_cycles", meas, 120);
    read_range("midrst_blank", 0, 1, 8'h20);
    probe("midrst_ready_after", K_RDY, 8'h01);

    tick();
    tick();
    check("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
